// File: rtl/div_sequencer.sv
// Multi-cycle restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Borrows the execution stage's shared 33-bit adder for one subtract per iteration.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            kill_i,
    output logic            alu_sel_o,
    output logic [XLEN:0]   alu_a_o,
    output logic [XLEN:0]   alu_b_o,
    input  logic [XLEN+1:0] alu_l_i,
    output logic            stall_o,
    output logic            div_wb,
    output logic [XLEN-1:0] Qo,
    output logic [XLEN-1:0] rem_o,
    output logic            RSIGN
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] r_d;
    logic            r_neg_q;
    logic            r_neg_r;

    logic            w_accept;
    logic            w_in_iter;
    logic [XLEN-1:0] w_dvd_mag;
    logic [XLEN-1:0] w_dvs_mag;
    logic [XLEN-1:0] w_q_neg;
    logic [XLEN-1:0] w_r_neg;
    logic [XLEN:0]   w_shift;
    logic            w_unused;

    assign w_accept  = (r_state == S_IDLE) & start_i & ~kill_i;
    assign w_in_iter = (r_state == S_ITER);

    assign w_dvd_mag = (signed_i & dividend_i[XLEN-1]) ? (~dividend_i + XLEN'(1)) : dividend_i;
    assign w_dvs_mag = (signed_i & divisor_i[XLEN-1])  ? (~divisor_i + XLEN'(1))  : divisor_i;
    assign w_q_neg   = ~r_q + XLEN'(1);
    assign w_r_neg   = ~r_r + XLEN'(1);

    // Before the last iteration R holds at most 31 dividend bits, so dropping R[31] loses nothing.
    assign w_shift   = {1'b0, r_r[XLEN-2:0], r_q[XLEN-1]};

    assign alu_sel_o = w_in_iter;
    assign alu_a_o   = w_in_iter ? w_shift : '0;
    assign alu_b_o   = w_in_iter ? {1'b0, r_d} : '0;
    assign w_unused  = alu_l_i[XLEN];

    assign stall_o   = w_accept | w_in_iter | (r_state == S_FIX);
    assign div_wb    = (r_state == S_DONE) & ~kill_i;
    assign Qo        = r_q;
    assign rem_o     = r_r;
    assign RSIGN     = r_neg_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (kill_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_neg_q <= signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        r_neg_r <= signed_i & dividend_i[XLEN-1];
                        r_d     <= w_dvs_mag;
                        r_count <= CW'(XLEN - 1);
                        if (divisor_i == '0) begin
                            r_q     <= '1;
                            r_r     <= dividend_i;
                            r_state <= S_DONE;
                        end else begin
                            r_q     <= w_dvd_mag;
                            r_r     <= '0;
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (!alu_l_i[XLEN+1]) begin
                        r_r <= alu_l_i[XLEN-1:0];
                        r_q <= {r_q[XLEN-2:0], 1'b1};
                    end else begin
                        r_r <= w_shift[XLEN-1:0];
                        r_q <= {r_q[XLEN-2:0], 1'b0};
                    end
                    r_count <= r_count - CW'(1);
                    if (r_count == '0)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_q     <= r_neg_q ? w_q_neg : r_q;
                    r_r     <= r_neg_r ? w_r_neg : r_r;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for RV32M DIV/DIVU/REM/REMU. It runs a restoring radix-2 division on the execution stage's shared 33-bit adder, owning the partial-remainder and quotient registers and feeding the adder one operand pair per cycle. It holds the execution stage with `stall_o` until the result is ready, then pulses `div_wb` for writeback.

## Interface
Parameters:
- `XLEN`, 32: operand width. Only 32 is supported.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `start_i`  in  1: execution stage has a valid divide or remainder instruction.
- `signed_i`  in  1: 1 selects DIV/REM, 0 selects DIVU/REMU. Sampled on accept.
- `dividend_i`  in  32: rs1 value. Sampled on accept.
- `divisor_i`  in  32: rs2 value. Sampled on accept.
- `kill_i`  in  1: pipeline flush. Aborts the operation in flight.
- `alu_sel_o`  out  1: execution muxes `alu_a_o`/`alu_b_o` into the adder and forces subtract.
- `alu_a_o`  out  33: adder operand A (shifted partial remainder, bit 32 = 0).
- `alu_b_o`  out  33: adder operand B (divisor magnitude, bit 32 = 0).
- `alu_l_i`  in  34: adder result, `alu_a_o - alu_b_o`, sign in bit 33.
- `stall_o`  out  1: hold the execution stage.
- `div_wb`  out  1: one-cycle result-valid pulse.
- `Qo`  out  32: final quotient.
- `rem_o`  out  32: final remainder.
- `RSIGN`  out  1: sign of the remainder (dividend sign for signed ops, else 0).

## Operation
States: IDLE, ITER, FIX, DONE.

IDLE:
- `start_i` is accepted when `start_i & !kill_i`.
- On accept, latch `neg_q = signed_i & (dividend[31] ^ divisor[31])` and `neg_r = signed_i & dividend[31]`.
- Latch magnitudes: Q = |dividend| and D = |divisor|. The absolute value is taken only when `signed_i`.
- Clear R to 0 and set count to 31.
- If divisor == 0: set Q = 0xFFFFFFFF and R = raw dividend, then go to DONE. Sign correction is skipped.
- Otherwise go to ITER.

ITER (32 cycles):
- `alu_a_o = {1'b0, R[30:0], Q[31]}` and `alu_b_o = {1'b0, D}`.
- If `alu_l_i[33] == 0`: R <= `alu_l_i[31:0]` and Q <= {Q[30:0], 1}.
- Otherwise R <= `alu_a_o[31:0]` and Q <= {Q[30:0], 0}.
- Decrement count. When count reaches 0, go to FIX.

FIX (1 cycle):
- Q <= `neg_q ? -Q : Q` and R <= `neg_r ? -R : R`.
- Negation uses an internal 32-bit incrementer. The shared adder is not used.
- Go to DONE.

DONE (1 cycle):
- `div_wb = 1`. `Qo`/`rem_o` hold the final values.
- Go to IDLE.

Output rules:
- `alu_sel_o` is 1 only in ITER.
- `stall_o = (IDLE & start_i & !kill_i) | ITER | FIX`. It is 0 in DONE, so the instruction retires with `div_wb`.
- `RSIGN = neg_r` and is valid while `div_wb`.
- Overflow (−2^31 / −1) needs no special path: the magnitude algorithm yields Q = 0x80000000 and R = 0.
- `kill_i` in any state forces IDLE on the next edge with no `div_wb`. `kill_i` in DONE suppresses `div_wb` in that cycle.
- `start_i` outside IDLE is ignored.

## Timing
- Reset: state IDLE, count 0, Q/R/D 0. Outputs after reset: `stall_o` 0, `div_wb` 0, `alu_sel_o` 0, `Qo` 0, `rem_o` 0, `RSIGN` 0, `alu_a_o`/`alu_b_o` 0.
- Reset mid-operation behaves like kill, and reset has priority over kill.
- Normal latency: accept in cycle 0, ITER in cycles 1–32, FIX in 33, `div_wb` in 34.
- Divide-by-zero latency: accept in cycle 0, `div_wb` in cycle 1.
- Back-to-back: a new `start_i` is accepted in the cycle after DONE at the earliest, because the block is in IDLE then.
- `alu_l_i` is combinational from `alu_a_o`/`alu_b_o` in the same cycle. No register sits in that path.

## Test plan
- DIVU 100/7: `div_wb` at cycle 34, Qo = 14, rem_o = 2, RSIGN = 0, and `stall_o` high for cycles 0–33.
- DIV −7/2: Qo = 0xFFFFFFFD (−3), rem_o = 0xFFFFFFFF (−1), RSIGN = 1. DIV 7/−2: Qo = −3, rem_o = 1.
- Divide by zero, DIV 0x80000005/0: `div_wb` at cycle 1, Qo = 0xFFFFFFFF, rem_o = 0x80000005.
- Overflow DIV 0x80000000/0xFFFFFFFF: Qo = 0x80000000, rem_o = 0.
- `kill_i` in cycle 10 of ITER: IDLE next cycle, `stall_o` 0, no `div_wb`. A new DIVU 9/3 started afterward gives Qo = 3 and rem_o = 0.
- `start_i` held high through a DIVU 0xFFFFFFFF/1: only one result (Qo = 0xFFFFFFFF), and the next accept happens in cycle 35.
